// File: rtl/fifo_pkt_reader_if.sv
// rtl/fifo_pkt_reader_if.sv - FIFO-side, downstream-side and status signals of the packet reader
interface fifo_pkt_reader_if #(
  parameter int pBITS     = 8,
  parameter int pCNT_BITS = 16
);
  logic                 ififo_empty;
  logic [pBITS-1:0]     ififo_data;
  logic                 ofifo_rd;
  logic                 itx_ready;
  logic                 otx_valid;
  logic [pBITS-1:0]     otx_data;
  logic                 otx_sop;
  logic                 otx_eop;
  logic                 obusy;
  logic [pCNT_BITS-1:0] opkt_cnt;
  logic [pCNT_BITS-1:0] oerr_cnt;

  modport master (
    input  ififo_empty, ififo_data, itx_ready,
    output ofifo_rd, otx_valid, otx_data, otx_sop, otx_eop, obusy, opkt_cnt, oerr_cnt
  );

  modport slave (
    output ififo_empty, ififo_data, itx_ready,
    input  ofifo_rd, otx_valid, otx_data, otx_sop, otx_eop, obusy, opkt_cnt, oerr_cnt
  );
endinterface

// File: rtl/fifo_pkt_reader.sv
// rtl/fifo_pkt_reader.sv - pops length-prefixed packets from a show-ahead FIFO and streams the payload
module fifo_pkt_reader #(
  parameter int pBITS     = 8,
  parameter int pCNT_BITS = 16
) (
  input  logic          iclk,
  input  logic          ireset,
  fifo_pkt_reader_if.master bus
);
  typedef enum logic {S_IDLE, S_DATA} state_t;

  state_t               state_q, state_d;
  logic [7:0]           rem_q, rem_d;
  logic [7:0]           len_q, len_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [pBITS-1:0]     tx_data_q, tx_data_d;
  logic                 tx_sop_q, tx_sop_d;
  logic                 tx_eop_q, tx_eop_d;
  logic [pCNT_BITS-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [pCNT_BITS-1:0] err_cnt_q, err_cnt_d;

  logic slot_free;
  logic hdr_pop;
  logic pay_pop;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    len_d      = len_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_sop_d   = tx_sop_q;
    tx_eop_d   = tx_eop_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_cnt_d  = err_cnt_q;

    slot_free = ~tx_valid_q | bus.itx_ready;
    // Header pop ignores the output slot so it overlaps a pending eop word
    hdr_pop   = (state_q == S_IDLE) & ~bus.ififo_empty;
    pay_pop   = (state_q == S_DATA) & ~bus.ififo_empty & slot_free;

    if (tx_valid_q && bus.itx_ready) begin
      tx_valid_d = 1'b0;
    end

    if (hdr_pop) begin
      len_d = bus.ififo_data[7:0];
      rem_d = bus.ififo_data[7:0];
      if (bus.ififo_data[7:0] == 8'd0) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end else begin
        state_d = S_DATA;
      end
    end

    if (pay_pop) begin
      tx_valid_d = 1'b1;
      tx_data_d  = bus.ififo_data;
      tx_sop_d   = (rem_q == len_q);
      tx_eop_d   = (rem_q == 8'd1);
      rem_d      = rem_q - 8'd1;
      if (rem_q == 8'd1) begin
        state_d   = S_IDLE;
        pkt_cnt_d = pkt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      len_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_sop_q   <= tx_sop_d;
      tx_eop_q   <= tx_eop_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Pop strobe is combinational, so gate it while reset is held
  assign bus.ofifo_rd  = ~ireset & (hdr_pop | pay_pop);
  assign bus.otx_valid = tx_valid_q;
  assign bus.otx_data  = tx_data_q;
  assign bus.otx_sop   = tx_sop_q;
  assign bus.otx_eop   = tx_eop_q;
  assign bus.obusy     = (state_q == S_DATA) | tx_valid_q;
  assign bus.opkt_cnt  = pkt_cnt_q;
  assign bus.oerr_cnt  = err_cnt_q;
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// tb/tb_fifo_pkt_reader.sv - self-checking bench for fifo_pkt_reader
module tb_fifo_pkt_reader;
  logic iclk;
  logic ireset;

  fifo_pkt_reader_if #(.pBITS(8), .pCNT_BITS(16)) bus ();

  fifo_pkt_reader #(.pBITS(8), .pCNT_BITS(16)) dut (
    .iclk  (iclk),
    .ireset(ireset),
    .bus   (bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } exp_t;

  logic [7:0] fifo_q[$];
  logic [7:0] pend_q[$];
  exp_t       exp_q[$];
  int         acc_cyc[$];
  int         exp_pkt, exp_err;
  int         checks, errors;
  int         cyc, pop_cnt, feed_pct;
  bit         ready_rand;
  logic       ready_fix;
  logic       last_rd;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_sop, prev_eop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_pkt(input int len, input bit direct, input logic [7:0] base);
    logic [7:0] w;
    if (direct) fifo_q.push_back(8'(len)); else pend_q.push_back(8'(len));
    if (len == 0) exp_err++; else exp_pkt++;
    for (int i = 0; i < len; i++) begin
      w = (base == 8'h00) ? 8'($urandom_range(255)) : base + 8'(i + 1);
      if (direct) fifo_q.push_back(w); else pend_q.push_back(w);
      exp_q.push_back('{w, (i == 0), (i == len - 1)});
    end
  endtask

  task automatic cycle();
    exp_t e;
    if (pend_q.size() > 0 && $urandom_range(99) < feed_pct) fifo_q.push_back(pend_q.pop_front());
    bus.ififo_empty = (fifo_q.size() == 0);
    bus.ififo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    bus.itx_ready   = ready_rand ? ($urandom_range(3) != 0) : ready_fix;
    @(negedge iclk);
    last_rd = bus.ofifo_rd;
    if (bus.ififo_empty) check("rd_when_empty", 32'(last_rd), 0);
    if (prev_stall) begin
      check("hold_valid", 32'(bus.otx_valid), 1);
      check("hold_data", 32'(bus.otx_data), 32'(prev_data));
      check("hold_flags", {30'd0, bus.otx_sop, bus.otx_eop}, {30'd0, prev_sop, prev_eop});
    end
    if (bus.otx_valid && bus.itx_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(bus.otx_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(bus.otx_data), 32'(e.d));
        check("out_sop", 32'(bus.otx_sop), 32'(e.sop));
        check("out_eop", 32'(bus.otx_eop), 32'(e.eop));
      end
      acc_cyc.push_back(cyc);
    end
    prev_stall = bus.otx_valid & ~bus.itx_ready;
    prev_data  = bus.otx_data;
    prev_sop   = bus.otx_sop;
    prev_eop   = bus.otx_eop;
    @(posedge iclk);
    #1;
    if (last_rd && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
    end
    cyc++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((fifo_q.size() > 0 || pend_q.size() > 0 || exp_q.size() > 0 || bus.obusy) && n < 3000) begin
      cycle();
      n++;
    end
    if (n >= 3000) check({tag, "_drain_timeout"}, 32'(n), 0);
    check({tag, "_pkt_cnt"}, 32'(bus.opkt_cnt), 32'(exp_pkt % 65536));
    check({tag, "_err_cnt"}, 32'(bus.oerr_cnt), 32'(exp_err % 65536));
  endtask

  task automatic do_reset();
    ireset = 1'b1;
    @(negedge iclk);
    check("rst_rd", 32'(bus.ofifo_rd), 0);
    check("rst_out", {bus.otx_valid, bus.otx_sop, bus.otx_eop, bus.obusy, bus.otx_data}, 0);
    check("rst_cnts", {bus.opkt_cnt, bus.oerr_cnt}, 0);
    @(posedge iclk);
    #1;
    ireset = 1'b0;
    fifo_q.delete();
    pend_q.delete();
    exp_q.delete();
    exp_pkt    = 0;
    exp_err    = 0;
    prev_stall = 1'b0;
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; cyc = 0; pop_cnt = 0;
    exp_pkt = 0; exp_err = 0;
    feed_pct = 100; ready_rand = 1'b0; ready_fix = 1'b1;
    prev_stall = 1'b0; prev_data = '0; prev_sop = 1'b0; prev_eop = 1'b0; last_rd = 1'b0;
    bus.ififo_empty = 1'b1;
    bus.ififo_data  = '0;
    bus.itx_ready   = 1'b0;
    ireset = 1'b1;
    #12;
    do_reset();

    // three-word packet streams on consecutive cycles
    acc_cyc.delete();
    push_pkt(3, 1'b1, 8'hA0);
    drain("t1");
    check("t1_words", 32'(acc_cyc.size()), 3);
    if (acc_cyc.size() == 3) begin
      check("t1_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 1);
      check("t1_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 1);
    end

    // back-to-back packets leave exactly one bubble
    do_reset();
    acc_cyc.delete();
    push_pkt(2, 1'b1, 8'h10);
    push_pkt(1, 1'b1, 8'h20);
    drain("t2");
    check("t2_words", 32'(acc_cyc.size()), 3);
    if (acc_cyc.size() == 3) begin
      check("t2_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 1);
      check("t2_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 2);
    end

    // zero-length header is dropped and counted
    do_reset();
    push_pkt(0, 1'b1, 8'h00);
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h55);
    exp_q.push_back('{8'h55, 1'b1, 1'b1});
    exp_pkt++;
    drain("t3");

    // downstream stall holds B1 and blocks pops
    do_reset();
    ready_fix = 1'b0;
    push_pkt(4, 1'b1, 8'hB0);
    n = 0;
    while (!bus.otx_valid && n < 20) begin
      cycle();
      n++;
    end
    check("t4_valid_seen", 32'(bus.otx_valid), 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_no_rd", 32'(last_rd), 0);
      check("t4_b1", 32'(bus.otx_data), 32'hB1);
    end
    ready_fix = 1'b1;
    drain("t4");

    // FIFO underrun mid-packet stalls then resumes
    do_reset();
    fifo_q.push_back(8'h02);
    fifo_q.push_back(8'hC1);
    exp_q.push_back('{8'hC1, 1'b1, 1'b0});
    for (int i = 0; i < 6; i++) cycle();
    check("t5_c1_out", 32'(exp_q.size()), 0);
    check("t5_busy", 32'(bus.obusy), 1);
    check("t5_pkt_pending", 32'(bus.opkt_cnt), 0);
    fifo_q.push_back(8'hC2);
    exp_q.push_back('{8'hC2, 1'b0, 1'b1});
    exp_pkt++;
    drain("t5");

    // reset mid-packet abandons it
    do_reset();
    pop_cnt = 0;
    push_pkt(5, 1'b1, 8'hE0);
    n = 0;
    while (pop_cnt < 3 && n < 20) begin
      cycle();
      n++;
    end
    check("t6_pops", 32'(pop_cnt), 3);
    do_reset();
    push_pkt(1, 1'b1, 8'hD0);
    drain("t6");

    // randomized traffic with FIFO gaps and downstream backpressure
    do_reset();
    feed_pct   = 70;
    ready_rand = 1'b1;
    for (int p = 0; p < 40; p++) begin
      push_pkt(($urandom_range(8) == 0) ? 0 : int'($urandom_range(12, 1)), 1'b0, 8'h00);
    end
    drain("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
